// File: rtl/global_pkg.sv
// Project-wide shared types.
package global_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage : global_pkg

// File: rtl/uart_pkg.sv
// UART transmitter types and elaboration-time helpers.
package uart_pkg;

  import global_pkg::*;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic logic calc_parity(input data_t data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// Clearable bit-period counter: counts 0..DIV-1 and flags the last two counts.
module uart_baud_tick #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_end_c,
  output logic pre_end_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign bit_end_c = (count_q == CNT_W'(DIV - 1));
  assign pre_end_c = (count_q == CNT_W'(DIV - 2));

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear_i || bit_end_c) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : uart_baud_tick

// File: rtl/uart_parity_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, parity, 1 or 2 stop bits.
module uart_parity_tx
  import global_pkg::*;
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  transmit,
  input  data_t tx_data,
  output logic  tx,
  output logic  tx_ready,
  output logic  tx_done
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int unsigned IDX_W    = 3;

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_parity_tx: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_parity_tx: CLK_FREQ/BAUD must be at least 2");
  end

  uart_tx_state_e   state_q, state_d;
  data_t            shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_done_q, tx_done_d;

  logic bit_end_c;
  logic pre_end_c;
  logic last_stop_c;

  // Counter is held at zero in IDLE so every frame starts on a fresh bit period.
  uart_baud_tick #(
    .DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (state_q == IDLE),
    .bit_end_c(bit_end_c),
    .pre_end_c(pre_end_c)
  );

  assign last_stop_c = (bit_idx_q == IDX_W'(STOP_BITS - 1));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    tx_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (transmit) begin
          shift_d    = tx_data;
          parity_d   = calc_parity(tx_data, 1'(PARITY_ODD));
          bit_idx_d  = '0;
          tx_d       = 1'b0;
          tx_ready_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_W'(7)) begin
            tx_d      = parity_q;
            bit_idx_d = '0;
            state_d   = PARITY;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          tx_d      = 1'b1;
          bit_idx_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        // Registered done must be raised one count early to land in the final clock.
        if (last_stop_c && pre_end_c) begin
          tx_done_d = 1'b1;
        end
        if (bit_end_c) begin
          if (last_stop_c) begin
            bit_idx_d  = '0;
            tx_ready_d = 1'b1;
            state_d    = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        bit_idx_d  = '0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_done  = tx_done_q;

endmodule : uart_parity_tx
